// File: rtl/rf_alu_sequencer_pkg.sv
// Shared types and constants for the register-file ALU sequencer.
// Opcodes, FSM state encoding and default widths.
package rf_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NOT   = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_LOADI = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Instruction handshake bus into the sequencer.
// master drives instructions, slave accepts them.
interface rf_alu_sequencer_if
  import rf_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [DW-1:0] imm;

  modport master (
    output instr_valid,
    output op,
    output rd,
    output rs1,
    output rs2,
    output imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  op,
    input  rd,
    input  rs1,
    input  rs2,
    input  imm,
    output instr_ready
  );

endinterface

// File: rtl/rf_alu_sequencer_alu.sv
// Combinational ALU: result and carry/borrow/shift-out.
// zero is left to the caller.
module rf_alu
  import rf_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y,
  output logic         cout
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the operation; the extra top bit of sum/diff is carry/borrow.
  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        y    = sum[W-1:0];
        cout = sum[W];
      end
      OP_SUB: begin
        y    = diff[W-1:0];
        cout = diff[W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y    = {a[W-2:0], 1'b0};
        cout = a[W-1];
      end
      OP_LOADI: y = imm;
      default: begin
        y    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Four-state execute/write-back controller in front of the RegisterFile.
// One instruction per four cycles: IDLE, READ, EXEC, WRITE.
module rf_alu_sequencer
  import rf_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  rf_alu_sequencer_if.slave   bus,
  output logic [AW-1:0]       rf_read_addr1,
  output logic [AW-1:0]       rf_read_addr2,
  input  logic [DW-1:0]       rf_read_data1,
  input  logic [DW-1:0]       rf_read_data2,
  output logic                rf_we,
  output logic [AW-1:0]       rf_write_addr,
  output logic [DW-1:0]       rf_write_data,
  output logic [DW-1:0]       result,
  output logic                zero,
  output logic                carry,
  output logic                done
);

  state_t        state;
  logic          ready;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_y;
  logic          alu_c;

  assign bus.instr_ready = ready;

  rf_alu #(.W(DW)) u_alu (
    .op   (op_q),
    .a    (op_a),
    .b    (op_b),
    .imm  (imm_q),
    .y    (alu_y),
    .cout (alu_c)
  );

  // Sequencer FSM; all outputs registered, write strobe lives only in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ready         <= 1'b1;
      op_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      rf_read_addr1 <= '0;
      rf_read_addr2 <= '0;
      rf_we         <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      result        <= '0;
      zero          <= 1'b1;
      carry         <= 1'b0;
      done          <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.instr_valid && ready) begin
            op_q          <= bus.op;
            rd_q          <= bus.rd;
            imm_q         <= bus.imm;
            rf_read_addr1 <= bus.rs1;
            rf_read_addr2 <= bus.rs2;
            ready         <= 1'b0;
            state         <= READ;
          end
        end
        READ: begin
          op_a  <= rf_read_data1;
          op_b  <= rf_read_data2;
          state <= EXEC;
        end
        EXEC: begin
          result        <= alu_y;
          zero          <= (alu_y == '0);
          carry         <= alu_c;
          rf_we         <= 1'b1;
          done          <= 1'b1;
          rf_write_addr <= rd_q;
          rf_write_data <= alu_y;
          state         <= WRITE;
        end
        WRITE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer with a behavioural RegisterFile.
// Directed table, dependency/throughput/reset sequences, random ops.
module tb_rf_alu_sequencer;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [7:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic [7:0] result;
  logic       rf_we, zero, carry, done;

  rf_alu_sequencer_if bus();

  rf_alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_we         (rf_we),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .result        (result),
    .zero          (zero),
    .carry         (carry),
    .done          (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rf_mem [8];
  assign rf_read_data1 = rf_mem[rf_read_addr1];
  assign rf_read_data2 = rf_mem[rf_read_addr2];

  int we_cnt = 0, done_cnt = 0, acc_cnt = 0;

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_write_addr] <= rf_write_data;
    if (rf_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;
  end

  int total = 0;
  int bad = 0;
  int mreg [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                input int imm, output int y, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = a + b; y = s % 256; c = (s > 255) ? 1 : 0; end
      1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 255 - a;
      6: begin s = a * 2; y = s % 256; c = (s > 255) ? 1 : 0; end
      default: y = imm;
    endcase
  endfunction

  // Called at a negedge while idle; returns at the negedge after WRITE.
  task automatic run_instr(input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input int ey,
                           input int ec, input string tag);
    int n, lat;
    bus.instr_valid = 1'b1;
    bus.op  = op[2:0];
    bus.rd  = rd[2:0];
    bus.rs1 = rs1[2:0];
    bus.rs2 = rs2[2:0];
    bus.imm = imm[7:0];
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      chk({tag, " ready timeout"}, 0, 1);
      bus.instr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.op  = 3'($urandom);
    bus.rd  = 3'($urandom);
    bus.rs1 = 3'($urandom);
    bus.rs2 = 3'($urandom);
    bus.imm = 8'($urandom);
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " rf_we"}, int'(rf_we), 1);
    chk({tag, " waddr"}, int'(rf_write_addr), rd);
    chk({tag, " wdata"}, int'(rf_write_data), ey);
    @(negedge clk);
    chk({tag, " result"}, int'(result), ey);
    chk({tag, " zero"}, int'(zero), (ey == 0) ? 1 : 0);
    chk({tag, " carry"}, int'(carry), ec);
    chk({tag, " reg"}, int'(rf_mem[rd[2:0]]), ey);
    chk({tag, " ready"}, int'(bus.instr_ready), 1);
    mreg[rd] = ey;
  endtask

  typedef struct {
    int op, rd, rs1, rs2, imm;
    int ey, ec;
  } vec_t;

  vec_t vt [10];

  initial begin
    int y, c, w0, a0, d0, lo, saved;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 8'h00;
      mreg[i] = 0;
    end
    bus.instr_valid = 1'b0;
    bus.op = 3'd0;
    bus.rd = 3'd0;
    bus.rs1 = 3'd0;
    bus.rs2 = 3'd0;
    bus.imm = 8'd0;

    vt[0] = '{7, 0, 0, 0, 'h55, 'h55, 0};
    vt[1] = '{7, 1, 0, 0, 'hAA, 'hAA, 0};
    vt[2] = '{0, 2, 0, 1, 0, 'hFF, 0};
    vt[3] = '{1, 3, 0, 1, 0, 'hAB, 1};
    vt[4] = '{7, 4, 0, 0, 'hFF, 'hFF, 0};
    vt[5] = '{7, 5, 0, 0, 'h01, 'h01, 0};
    vt[6] = '{0, 6, 4, 5, 0, 'h00, 1};
    vt[7] = '{6, 7, 4, 3, 0, 'hFE, 1};
    vt[8] = '{0, 0, 0, 0, 0, 'hAA, 0};
    vt[9] = '{0, 1, 0, 0, 0, 'h54, 1};

    repeat (2) @(negedge clk);
    chk("rst rf_we", int'(rf_we), 0);
    chk("rst done", int'(done), 0);
    chk("rst raddr1", int'(rf_read_addr1), 0);
    chk("rst raddr2", int'(rf_read_addr2), 0);
    chk("rst waddr", int'(rf_write_addr), 0);
    chk("rst wdata", int'(rf_write_data), 0);
    chk("rst result", int'(result), 0);
    chk("rst zero", int'(zero), 1);
    chk("rst carry", int'(carry), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", int'(bus.instr_ready), 1);

    for (int i = 0; i < 10; i++)
      run_instr(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm,
                vt[i].ey, vt[i].ec, $sformatf("vec%0d", i));

    a0 = acc_cnt;
    d0 = done_cnt;
    lo = 0;
    bus.instr_valid = 1'b1;
    bus.op = 3'd0;
    bus.rd = 3'd2;
    bus.rs1 = 3'd0;
    bus.rs2 = 3'd1;
    for (int i = 0; i < 12; i++) begin
      if (!bus.instr_ready) lo++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold accepts", acc_cnt - a0, 3);
    chk("hold dones", done_cnt - d0, 3);
    chk("hold ready low", lo, 9);
    model(0, mreg[0], mreg[1], 0, y, c);
    mreg[2] = y;
    chk("hold r2", int'(rf_mem[2]), y);

    saved = int'(rf_mem[3]);
    bus.instr_valid = 1'b1;
    bus.op = 3'd0;
    bus.rd = 3'd3;
    bus.rs1 = 3'd0;
    bus.rs2 = 3'd1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    w0 = we_cnt;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("abort result", int'(result), 0);
    chk("abort zero", int'(zero), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort no we", we_cnt - w0, 0);
    chk("abort no done", done_cnt - d0, 0);
    chk("abort r3", int'(rf_mem[3]), saved);
    chk("abort ready", int'(bus.instr_ready), 1);
    chk("abort carry", int'(carry), 0);

    for (int i = 0; i < 40; i++) begin
      int op, rd, rs1, rs2, imm;
      op  = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 255));
      model(op, mreg[rs1], mreg[rs2], imm, y, c);
      run_instr(op, rd, rs1, rs2, imm, y, c, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 8; i++)
      chk($sformatf("final r%0d", i), int'(rf_mem[i]), mreg[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
